// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I datapath: FETCH/DECODE/EXECUTE/MEM/WB sequencing, IR/A/B/ALUOut/MDR latches,
// req/ack memory ports. ImmSel: 0=I 1=S 2=B 3=U 4=J. ALUSel: 0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=SLL 6=SRL 7=SRA.
module multicycle_datapath #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int INST_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int IMMSEL_WIDTH   = 3,
    parameter int ALUSEL_WIDTH   = 3,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    PCSel,
    input  logic                    RegWEn,
    input  logic                    BrUn,
    input  logic                    BSel,
    input  logic                    MemRW,
    input  logic                    MemAcc,
    input  logic [IMMSEL_WIDTH-1:0] ImmSel,
    input  logic [1:0]              ASel,
    input  logic [1:0]              WBSel,
    input  logic [ALUSEL_WIDTH-1:0] ALUSel,
    output logic [INST_WIDTH-1:0]   inst_o,
    output logic                    BrEq,
    output logic                    BrLT,
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic [INST_WIDTH-1:0]   imem_rdata,
    input  logic                    imem_ack,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [PC_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata,
    input  logic                    dmem_ack,
    output logic [2:0]              state_o,
    output logic                    retire,
    output logic [CNT_WIDTH-1:0]    instret
);
    localparam int NREGS = 2 ** REG_ADDR_WIDTH;
    localparam int SHW   = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [INST_WIDTH-1:0]   ir_q, ir_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [CNT_WIDTH-1:0]    instret_q, instret_d;
    logic [DATA_WIDTH-1:0]   rf_q [NREGS];
    logic [DATA_WIDTH-1:0]   rf_d [NREGS];

    logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
    logic [31:0]             imm32;
    logic [DATA_WIDTH-1:0]   imm, alu_a, alu_b, alu_res, wb_val;
    logic [SHW-1:0]          shamt;
    logic [PC_WIDTH-1:0]     pc_plus4;
    logic                    unused_ir;

    assign rs1       = ir_q[15 +: REG_ADDR_WIDTH];
    assign rs2       = ir_q[20 +: REG_ADDR_WIDTH];
    assign rd        = ir_q[7 +: REG_ADDR_WIDTH];
    assign unused_ir = ^ir_q[6:0];
    assign pc_plus4  = pc_q + PC_WIDTH'(4);

    always_comb begin
        imm32 = '0;
        case (ImmSel)
            IMMSEL_WIDTH'(0): imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            IMMSEL_WIDTH'(1): imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            IMMSEL_WIDTH'(2): imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            IMMSEL_WIDTH'(3): imm32 = {ir_q[31:12], 12'b0};
            IMMSEL_WIDTH'(4): imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:          imm32 = '0;
        endcase
    end
    assign imm = DATA_WIDTH'($signed(imm32));

    always_comb begin
        alu_a = '0;
        case (ASel)
            2'd0:    alu_a = a_q;
            2'd1:    alu_a = DATA_WIDTH'(pc_q);
            default: alu_a = '0;
        endcase
        alu_b = BSel ? imm : b_q;
        shamt = alu_b[SHW-1:0];
        alu_res = '0;
        case (ALUSel)
            ALUSEL_WIDTH'(0): alu_res = alu_a + alu_b;
            ALUSEL_WIDTH'(1): alu_res = alu_a - alu_b;
            ALUSEL_WIDTH'(2): alu_res = alu_a & alu_b;
            ALUSEL_WIDTH'(3): alu_res = alu_a | alu_b;
            ALUSEL_WIDTH'(4): alu_res = alu_a ^ alu_b;
            ALUSEL_WIDTH'(5): alu_res = alu_a << shamt;
            ALUSEL_WIDTH'(6): alu_res = alu_a >> shamt;
            ALUSEL_WIDTH'(7): alu_res = DATA_WIDTH'($signed(alu_a) >>> shamt);
            default:          alu_res = '0;
        endcase
        wb_val = '0;
        case (WBSel)
            2'd0:    wb_val = mdr_q;
            2'd1:    wb_val = alu_out_q;
            2'd2:    wb_val = DATA_WIDTH'(pc_plus4);
            default: wb_val = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        instret_d = instret_q;
        rf_d      = rf_q;
        case (state_q)
            S_FETCH: if (imem_ack) begin
                ir_d    = imem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = (rs1 == '0) ? '0 : rf_q[rs1];
                b_d     = (rs2 == '0) ? '0 : rf_q[rs2];
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_out_d = alu_res;
                state_d   = MemAcc ? S_MEM : S_WB;
            end
            S_MEM: if (dmem_ack) begin
                if (!MemRW) mdr_d = dmem_rdata;
                state_d = S_WB;
            end
            S_WB: begin
                if (RegWEn && rd != '0) rf_d[rd] = wb_val;
                pc_d      = PCSel ? PC_WIDTH'(alu_out_q) : pc_plus4;
                instret_d = instret_q + CNT_WIDTH'(1);
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            instret_q <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            instret_q <= instret_d;
            rf_q      <= rf_d;
        end
    end

    // Strobes decode the registered state; reset masks them so nothing is requested while held.
    assign inst_o     = ir_q;
    assign state_o    = state_q;
    assign imem_req   = (state_q == S_FETCH) && !reset;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM) && !reset;
    assign dmem_we    = dmem_req && MemRW;
    assign dmem_addr  = PC_WIDTH'(alu_out_q);
    assign dmem_wdata = b_q;
    assign retire     = (state_q == S_WB) && !reset;
    assign instret    = instret_q;
    assign BrEq       = !reset && (a_q == b_q);
    assign BrLT       = !reset && (BrUn ? (a_q < b_q) : ($signed(a_q) < $signed(b_q)));
endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: the bench plays control decoder and both memories.
module tb_multicycle_datapath;
    localparam logic [31:0] RPC = 32'h100;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd4;
    localparam logic [2:0] ALU_ADD = 3'd0;

    logic        clk = 1'b0, reset = 1'b1;
    logic        pcsel = 0, regwen = 0, brun = 0, bsel = 0, memrw = 0, memacc = 0;
    logic [2:0]  immsel = '0, alusel = '0;
    logic [1:0]  asel = '0, wbsel = '0;
    logic [31:0] inst_o, imem_addr, imem_rdata = '0, dmem_addr, dmem_wdata, dmem_rdata = '0, instret;
    logic        breq, brlt, imem_req, imem_ack = 0, dmem_req, dmem_we, dmem_ack = 0, retire;
    logic [2:0]  state_o;
    int          cyc = 0, fetch_cyc = 0, wb_cyc = 0;
    int          n_chk = 0, n_pass = 0;

    multicycle_datapath #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .PCSel(pcsel), .RegWEn(regwen), .BrUn(brun), .BSel(bsel),
        .MemRW(memrw), .MemAcc(memacc), .ImmSel(immsel), .ASel(asel), .WBSel(wbsel),
        .ALUSel(alusel), .inst_o(inst_o), .BrEq(breq), .BrLT(brlt), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .state_o(state_o), .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_ctl(input logic pcs, input logic rwe, input logic bs, input logic mrw,
                           input logic macc, input logic [2:0] imm, input logic [1:0] as,
                           input logic [1:0] wb, input logic [2:0] alu);
        pcsel = pcs; regwen = rwe; bsel = bs; memrw = mrw; memacc = macc;
        immsel = imm; asel = as; wbsel = wb; alusel = alu;
    endtask

    task automatic do_fetch(input logic [31:0] ins, input int dly, input logic [31:0] pc,
                            input logic [31:0] icnt);
        for (int i = 0; i <= dly; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("fetch_state", 32'(state_o), 32'd0);
                chk("fetch_instret", instret, icnt);
                fetch_cyc = cyc;
            end
            chk("imem_req", 32'(imem_req), 32'd1);
            chk("imem_addr", imem_addr, pc);
            chk("fetch_retire", 32'(retire), 32'd0);
            if (i == dly) begin
                imem_rdata = ins;
                imem_ack   = 1'b1;
            end
        end
        @(posedge clk); #1;
        imem_ack = 1'b0; imem_rdata = '0;
    endtask

    task automatic step(input logic [2:0] st);
        @(negedge clk);
        chk("state", 32'(state_o), 32'(st));
        chk("retire_low", 32'(retire), 32'd0);
        chk("imem_req_low", 32'(imem_req), 32'd0);
        chk("dmem_req_low", 32'(dmem_req), 32'd0);
    endtask

    task automatic do_mem(input int dly, input logic [31:0] rdata, input logic [31:0] addr,
                          input logic we, input logic [31:0] wdata);
        for (int i = 0; i <= dly; i++) begin
            @(negedge clk);
            chk("mem_state", 32'(state_o), 32'd3);
            chk("dmem_req", 32'(dmem_req), 32'd1);
            chk("dmem_addr", dmem_addr, addr);
            chk("dmem_we", 32'(dmem_we), 32'(we));
            chk("dmem_wdata", dmem_wdata, wdata);
            if (i == dly) begin
                dmem_rdata = rdata;
                dmem_ack   = 1'b1;
            end
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    task automatic do_wb(input logic [31:0] icnt, input logic [31:0] npc);
        @(negedge clk);
        chk("wb_state", 32'(state_o), 32'd4);
        chk("wb_retire", 32'(retire), 32'd1);
        chk("wb_dmem_req", 32'(dmem_req), 32'd0);
        wb_cyc = cyc;
        @(posedge clk); #1;
        chk("post_wb_retire", 32'(retire), 32'd0);
        chk("post_wb_instret", instret, icnt);
        chk("next_pc", imem_addr, npc);
    endtask

    initial begin
        // Reset held for two edges; outputs quiet while held.
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RPC);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_instret", instret, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADDI x5,x0,7 with fetch ack delayed two cycles
        set_ctl(0, 1, 1, 0, 0, IMM_I, 2'd0, 2'd1, ALU_ADD);
        do_fetch(32'h00700293, 2, 32'h100, 32'd0);
        step(3'd1);
        chk("ir_addi", inst_o, 32'h00700293);
        step(3'd2);
        do_wb(32'd1, 32'h104);
        chk("retire_cycle_ordinal", 32'(wb_cyc - fetch_cyc + 1), 32'd6);
        chk("x5", dut.rf_q[5], 32'd7);

        // LW x6,4(x5) with data ack delayed three cycles
        set_ctl(0, 1, 1, 0, 1, IMM_I, 2'd0, 2'd0, ALU_ADD);
        do_fetch(32'h0042A303, 0, 32'h104, 32'd1);
        step(3'd1); step(3'd2);
        do_mem(3, 32'hDEADBEEF, 32'd11, 1'b0, 32'd0);
        do_wb(32'd2, 32'h108);
        chk("x6_load", dut.rf_q[6], 32'hDEADBEEF);

        // SW x6,0(x0)
        set_ctl(0, 0, 1, 1, 1, IMM_S, 2'd0, 2'd1, ALU_ADD);
        do_fetch(32'h00602023, 0, 32'h108, 32'd2);
        step(3'd1); step(3'd2);
        do_mem(0, 32'h12345678, 32'd0, 1'b1, 32'hDEADBEEF);
        do_wb(32'd3, 32'h10C);
        chk("x6_after_store", dut.rf_q[6], 32'hDEADBEEF);

        // ADDI x1,x0,-1 (A=x0, B=x31 both zero -> BrEq)
        set_ctl(0, 1, 1, 0, 0, IMM_I, 2'd0, 2'd1, ALU_ADD);
        do_fetch(32'hFFF00093, 0, 32'h10C, 32'd3);
        step(3'd1); step(3'd2);
        chk("breq_equal", 32'(breq), 32'd1);
        do_wb(32'd4, 32'h110);
        chk("x1", dut.rf_q[1], 32'hFFFFFFFF);

        // ADDI x2,x0,1 with stray acks while no request is pending
        do_fetch(32'h00100113, 0, 32'h110, 32'd4);
        step(3'd1);
        imem_ack = 1'b1; imem_rdata = 32'hFFFFFFFF; dmem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0;
        step(3'd2);
        chk("ir_stray_ack", inst_o, 32'h00100113);
        do_wb(32'd5, 32'h114);
        chk("x2", dut.rf_q[2], 32'd1);

        // BLT x1,x2,+16 taken
        set_ctl(1, 0, 1, 0, 0, IMM_B, 2'd1, 2'd1, ALU_ADD);
        do_fetch(32'h0020C863, 0, 32'h114, 32'd5);
        step(3'd1); step(3'd2);
        chk("brlt_signed", 32'(brlt), 32'd1);
        chk("breq_ne", 32'(breq), 32'd0);
        brun = 1'b1; #1;
        chk("brlt_unsigned", 32'(brlt), 32'd0);
        brun = 1'b0;
        do_wb(32'd6, 32'h124);

        // ADDI x0,x0,5
        set_ctl(0, 1, 1, 0, 0, IMM_I, 2'd0, 2'd1, ALU_ADD);
        do_fetch(32'h00500013, 0, 32'h124, 32'd6);
        step(3'd1); step(3'd2);
        do_wb(32'd7, 32'h128);
        chk("x0_addi", dut.rf_q[0], 32'd0);

        // JAL x0,+0xD8 -> 0x200, then JAL x8,+8 at 0x200
        set_ctl(1, 1, 1, 0, 0, IMM_J, 2'd1, 2'd2, ALU_ADD);
        do_fetch(32'h0D80006F, 0, 32'h128, 32'd7);
        step(3'd1); step(3'd2);
        do_wb(32'd8, 32'h200);
        chk("x0_jal", dut.rf_q[0], 32'd0);
        do_fetch(32'h0080046F, 0, 32'h200, 32'd8);
        step(3'd1); step(3'd2);
        do_wb(32'd9, 32'h208);
        chk("x8_link", dut.rf_q[8], 32'h204);

        // LW interrupted by reset in MEM; acks during reset are ignored
        set_ctl(0, 1, 1, 0, 1, IMM_I, 2'd0, 2'd0, ALU_ADD);
        do_fetch(32'h0042A303, 0, 32'h208, 32'd9);
        step(3'd1); step(3'd2);
        @(negedge clk);
        chk("pre_rst_dmem_req", 32'(dmem_req), 32'd1);
        chk("pre_rst_dmem_addr", dmem_addr, 32'd11);
        reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h55;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("mid_rst_imem_req", 32'(imem_req), 32'd0);
        chk("mid_rst_state", 32'(state_o), 32'd0);
        chk("mid_rst_imem_addr", imem_addr, RPC);
        chk("mid_rst_instret", instret, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        chk("x6_cleared", dut.rf_q[6], 32'd0);

        // ADDI x9,x0,3 from RESET_PC
        set_ctl(0, 1, 1, 0, 0, IMM_I, 2'd0, 2'd1, ALU_ADD);
        do_fetch(32'h00300493, 0, RPC, 32'd0);
        step(3'd1); step(3'd2);
        do_wb(32'd1, 32'h104);
        chk("x9", dut.rf_q[9], 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
